// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: opcodes, fetch FSM states, reset PC,
// prefetch FIFO geometry and an address alignment helper.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JALPC = 6'b011111;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Prefetch FIFO entry is {pc, instr}
  localparam int FETCH_FIFO_DEPTH = 2;
  localparam int FETCH_ENTRY_W    = 64;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_e;

  // Fetch addresses are always word aligned; low two bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {pc, instr} buffer between instruction memory and decode.
// Only built when INSTR_FETCH_PREFETCH_EN is defined; in the default build
// this file is intentionally empty so no unused module is elaborated.
`ifdef INSTR_FETCH_PREFETCH_EN
module fetch_fifo
  import mips_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [FETCH_ENTRY_W-1:0] push_data_i,
  input  logic                     pop_i,
  output logic [FETCH_ENTRY_W-1:0] rdata_o,
  output logic                     empty_o,
  output logic [1:0]               count_o
);

  logic [FETCH_ENTRY_W-1:0] mem_q [FETCH_FIFO_DEPTH];
  logic                     wr_q, rd_q;
  logic [1:0]               cnt_q;
  logic                     push_ok, pop_ok;

  assign push_ok = push_i & (cnt_q != 2'd2);
  assign pop_ok  = pop_i  & (cnt_q != 2'd0);

  // Storage and pointers; flush drops contents but leaves stale data, which
  // is harmless because empty_o masks it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FETCH_FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else if (flush_i) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= ~wr_q;
      end
      if (pop_ok) rd_q <= ~rd_q;
      cnt_q <= cnt_q + 2'(push_ok) - 2'(pop_ok);
    end
  end

  assign rdata_o = mem_q[rd_q];
  assign empty_o = (cnt_q == 2'd0);
  assign count_o = cnt_q;

endmodule
`endif

// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding memory read, redirect from
// beq/jalpc, presents {instr, opcode, pc_out} to decode with valid/ready.
// Define INSTR_FETCH_PREFETCH_EN to insert a 2-entry prefetch FIFO; the
// default build uses a single holding register (FETCH/WAIT/HOLD loop).
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic         has_space;
  logic         xfer;
  logic         rsp_take;

  assign xfer     = instr_valid & instr_ready;
  // A response that coincides with a redirect belongs to the old stream.
  assign rsp_take = (state_q == S_WAIT) & imem_valid & ~redirect;

  // Request is suppressed during a redirect so no stale-address read leaves.
  assign imem_req  = (state_q == S_FETCH) & ~reset & ~redirect & has_space;
  assign imem_addr = pc_q;
  assign opcode    = instr[31:26];

  // Fetch sequencing and PC; redirect overrides everything except reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= word_align(RESET_PC);
    end else if (redirect) begin
      pc_q <= word_align(redirect_pc);
      // With a read still in flight, its response must be swallowed first.
      if ((state_q == S_WAIT || state_q == S_DRAIN) && !imem_valid)
        state_q <= S_DRAIN;
      else
        state_q <= S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: if (has_space) state_q <= S_WAIT;
        S_WAIT: if (imem_valid) begin
          pc_q <= pc_q + 32'd4;
`ifdef INSTR_FETCH_PREFETCH_EN
          state_q <= S_FETCH;
`else
          state_q <= S_HOLD;
`endif
        end
        S_HOLD:  if (xfer) state_q <= S_FETCH;
        S_DRAIN: if (imem_valid) state_q <= S_FETCH;
        default: state_q <= S_FETCH;
      endcase
    end
  end

`ifdef INSTR_FETCH_PREFETCH_EN
  logic [1:0]               fifo_cnt;
  logic                     fifo_empty;
  logic [FETCH_ENTRY_W-1:0] fifo_head;

  // In FETCH nothing is outstanding, so occupancy alone decides.
  assign has_space = (fifo_cnt < 2'd2);

  fetch_fifo u_fifo (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (redirect),
    .push_i      (rsp_take),
    .push_data_i ({pc_q, imem_rdata}),
    .pop_i       (xfer),
    .rdata_o     (fifo_head),
    .empty_o     (fifo_empty),
    .count_o     (fifo_cnt)
  );

  assign instr       = fifo_head[31:0];
  assign pc_out      = fifo_head[63:32];
  assign instr_valid = ~fifo_empty;
`else
  logic [31:0] instr_q, pc_out_q;
  logic        valid_q;

  assign has_space = 1'b1;

  // Holding register: load on response, drop valid on transfer or redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q  <= '0;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
    end else if (redirect) begin
      valid_q <= 1'b0;
    end else if (rsp_take) begin
      instr_q  <= imem_rdata;
      pc_out_q <= pc_q;
      valid_q  <= 1'b1;
    end else if (xfer) begin
      valid_q <= 1'b0;
    end
  end

  assign instr       = instr_q;
  assign pc_out      = pc_out_q;
  assign instr_valid = valid_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, fetch/hold, redirect in WAIT and
// coincident with a response, redirect with a transfer, PC wrap, and reset
// abandoning an outstanding read.
module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  int n_pass  = 0;
  int n_total = 0;

  instr_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .opcode      (opcode),
    .pc_out      (pc_out),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1; imem_valid = 1'b0; imem_rdata = '0;
    instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;

    @(negedge clk);
    chk("rst_req",   imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_op",    opcode, 0);
    chk("rst_pcout", pc_out, 0);
    reset = 1'b0; #1;
    chk("first_req",  imem_req, 1);
    chk("first_addr", imem_addr, 32'h0);

    @(negedge clk);               // WAIT
    chk("wait_noreq", imem_req, 0);
    imem_valid = 1'b1; imem_rdata = 32'h8C22_0004;

    @(negedge clk);
    imem_valid = 1'b0; #1;
    chk("lw_valid", instr_valid, 1);
    chk("lw_op",    opcode, 6'b100011);
    chk("lw_instr", instr, 32'h8C22_0004);
    chk("lw_pcout", pc_out, 32'h0);

`ifdef INSTR_FETCH_PREFETCH_EN
    // Prefetch keeps fetching while decode stalls, up to two buffered words.
    chk("pf_req1",  imem_req, 1);
    chk("pf_addr1", imem_addr, 32'h4);
    @(negedge clk);               // WAIT for addr 4
    imem_valid = 1'b1; imem_rdata = 32'h8C23_0008;
    @(negedge clk);
    imem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("pf_full_noreq", imem_req, 0);
      chk("pf_hold_instr", instr, 32'h8C22_0004);
      chk("pf_hold_valid", instr_valid, 1);
      @(negedge clk);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0; #1;
    chk("pf_2nd_valid", instr_valid, 1);
    chk("pf_2nd_instr", instr, 32'h8C23_0008);
    chk("pf_2nd_pcout", pc_out, 32'h4);
    chk("pf_req2",  imem_req, 1);
    chk("pf_addr2", imem_addr, 32'h8);
`else
    chk("hold_noreq0", imem_req, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_instr", instr, 32'h8C22_0004);
      chk("hold_valid", instr_valid, 1);
      chk("hold_noreq", imem_req, 0);
      // A stray response in HOLD must be ignored.
      if (i == 2) begin imem_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF; end
      else imem_valid = 1'b0;
    end
    instr_ready = 1'b1;

    @(negedge clk);
    instr_ready = 1'b0; #1;
    chk("xfer_clr",  instr_valid, 0);
    chk("next_req",  imem_req, 1);
    chk("next_addr", imem_addr, 32'h4);

    // Redirect while waiting on addr 4; low address bits must be dropped.
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h43; #1;
    chk("wait_req", imem_req, 0);
    @(negedge clk);               // DRAIN
    redirect = 1'b0; imem_valid = 1'b1; imem_rdata = 32'h1111_1111; #1;
    chk("drain_noreq", imem_req, 0);
    chk("drain_valid", instr_valid, 0);
    @(negedge clk);
    imem_valid = 1'b0; #1;
    chk("redir_req",  imem_req, 1);
    chk("redir_addr", imem_addr, 32'h40);
    chk("redir_noval", instr_valid, 0);
    @(negedge clk);
    imem_valid = 1'b1; imem_rdata = 32'hAC43_0008;
    @(negedge clk);
    imem_valid = 1'b0; #1;
    chk("sw_valid", instr_valid, 1);
    chk("sw_pcout", pc_out, 32'h40);
    chk("sw_op",    opcode, 6'b101011);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0; #1;
    chk("seq_addr", imem_addr, 32'h44);
    chk("seq_req",  imem_req, 1);

    // Redirect coincident with the response: word 12345678 is dropped.
    @(negedge clk);
    imem_valid = 1'b1; imem_rdata = 32'h1234_5678;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    imem_valid = 1'b0; redirect = 1'b0; #1;
    chk("coinc_noval", instr_valid, 0);
    chk("coinc_req",   imem_req, 1);
    chk("coinc_addr",  imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    imem_valid = 1'b1; imem_rdata = 32'h7C00_0000;
    @(negedge clk);
    imem_valid = 1'b0; #1;
    chk("jal_valid", instr_valid, 1);
    chk("jal_instr", instr, 32'h7C00_0000);
    chk("jal_op",    opcode, 6'b011111);
    chk("jal_pcout", pc_out, 32'hFFFF_FFFC);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0; #1;
    chk("wrap_req",  imem_req, 1);
    chk("wrap_addr", imem_addr, 32'h0);

    // Transfer and redirect in the same cycle.
    @(negedge clk);
    imem_valid = 1'b1; imem_rdata = 32'h0022_1820;
    @(negedge clk);
    imem_valid = 1'b0; #1;
    chk("rt_valid", instr_valid, 1);
    chk("rt_instr", instr, 32'h0022_1820);
    chk("rt_op",    opcode, 6'b000000);
    chk("rt_pcout", pc_out, 32'h0);
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h80;
    @(negedge clk);
    instr_ready = 1'b0; redirect = 1'b0; #1;
    chk("xr_noval", instr_valid, 0);
    chk("xr_req",   imem_req, 1);
    chk("xr_addr",  imem_addr, 32'h80);

    // Reset during WAIT, then a late response arrives.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    imem_valid = 1'b1; imem_rdata = 32'hCAFE_F00D; #1;
    chk("mrst_valid", instr_valid, 0);
    chk("mrst_instr", instr, 0);
    chk("mrst_pcout", pc_out, 0);
    chk("mrst_req",   imem_req, 0);
    @(negedge clk);
    reset = 1'b0; #1;
    chk("rel_req",  imem_req, 1);
    chk("rel_addr", imem_addr, 32'h0);
    @(negedge clk);
    imem_valid = 1'b1; imem_rdata = 32'h8C22_0004; #1;
    chk("rel_late_ign", instr_valid, 0);
    @(negedge clk);
    imem_valid = 1'b0; #1;
    chk("rel_valid", instr_valid, 1);
    chk("rel_instr", instr, 32'h8C22_0004);
    chk("rel_pcout", pc_out, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 Parameter RESET_PC, default 32'h00000000: the first fetch address after reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 imem_req  output  1  one-cycle read request to instruction memory.
REQ-006 imem_addr  output  32  word-aligned fetch address, valid while imem_req=1.
REQ-007 imem_valid  input  1  read data returned, one or more cycles after imem_req.
REQ-008 imem_rdata  input  32  instruction word, valid with imem_valid.
REQ-009 instr  output  32  instruction presented to decode.
REQ-010 opcode  output  6  instr[31:26]; drives the main control decoder opcode input.
REQ-011 pc_out  output  32  fetch address of the presented instr.
REQ-012 instr_valid  output  1  instr, opcode and pc_out are valid.
REQ-013 instr_ready  input  1  decode accepts; a transfer occurs when instr_valid=1 and instr_ready=1.
REQ-014 redirect  input  1  one-cycle pulse from a taken beq or a jalpc; redirects fetch.
REQ-015 redirect_pc  input  32  new fetch address, sampled when redirect=1.

Function
REQ-016 The FSM SHALL have states FETCH, WAIT, HOLD and DRAIN, with at most one memory request outstanding.
REQ-017 FETCH: assert imem_req with imem_addr=pc, then go to WAIT.
REQ-018 WAIT: on imem_valid, register imem_rdata into instr, set pc_out=pc and pc=pc+4, set instr_valid=1 on the next edge, then go to HOLD.
REQ-019 HOLD: instr, opcode, pc_out and instr_valid SHALL hold stable until a transfer occurs; on the transfer edge, clear instr_valid and go to FETCH.
REQ-020 Latency: the first imem_req SHALL assert in the first cycle after reset deasserts; instr_valid SHALL rise one cycle after imem_valid.
REQ-021 pc arithmetic SHALL be modulo 2^32: 32'hFFFFFFFC + 4 = 32'h00000000.
REQ-022 Redirect SHALL have priority over all other events: pc <= redirect_pc, instr_valid <= 0, and all buffered instructions are flushed.
REQ-023 A redirect in WAIT SHALL go to DRAIN; DRAIN discards the next imem_valid, then goes to FETCH at redirect_pc.
REQ-024 A redirect in the same cycle as imem_valid SHALL discard that response and go to FETCH.
REQ-025 A redirect in the same cycle as a transfer SHALL let the transfer complete; the next instruction presented comes from redirect_pc.
REQ-026 imem_valid outside WAIT and DRAIN SHALL be ignored.
REQ-027 redirect_pc[1:0] SHALL be ignored; addresses are forced word-aligned.

Reset
REQ-028 On reset: pc=RESET_PC, state=FETCH, imem_req=0, instr=0, opcode=0, pc_out=0, instr_valid=0, buffer empty.
REQ-029 Reset asserted mid-operation SHALL abandon any outstanding request without waiting for its response.

Configuration
REQ-030 Macro INSTR_FETCH_PREFETCH_EN SHALL select the buffering mode.
REQ-031 When defined: a 2-entry FIFO sits between memory and decode; FETCH is re-entered whenever FIFO occupancy plus outstanding requests is less than 2; instr_valid = FIFO not empty; the HOLD state is unused.
REQ-032 When undefined: a single holding register is used and behaviour is exactly as REQ-017..REQ-019.
REQ-033 Redirect and reset rules SHALL be identical in both modes.

Structure
REQ-034 Shared package mips_pkg SHALL hold: OP_RTYPE=6'b000000, OP_LW=6'b100011, OP_SW=6'b101011, OP_BEQ=6'b000100, OP_JALPC=6'b011111, the FSM state enum, and the default RESET_PC.
REQ-035 The FIFO SHALL be sub-module fetch_fifo (depth 2, width 64 = {pc, instr}, with a flush input), instantiated only under INSTR_FETCH_PREFETCH_EN.

Verification
REQ-036 Reset, then memory returns 32'h8C220004 one cycle after the request to addr 0 -> instr_valid=1, opcode=6'b100011, pc_out=0; next imem_addr=4.
REQ-037 instr_ready=0 for 5 cycles -> instr stable; no new request (macro off), or exactly 2 words buffered (macro on).
REQ-038 redirect to 32'h40 during WAIT -> the pending response is discarded and the next imem_addr=32'h40; the first presented pc_out=32'h40.
REQ-039 redirect coincident with imem_valid -> that word is never presented; the next fetch is from redirect_pc.
REQ-040 pc=32'hFFFFFFFC is fetched -> the next imem_addr=32'h00000000.
REQ-041 reset asserted in WAIT, followed by a late imem_valid -> outputs hold reset values; the first request after release goes to RESET_PC.
